// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the wide add/subtract sequencer.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wide_add_state_t;

  // Chunk counter width; a single-chunk build still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n_chunks);
    return (n_chunks > 1) ? $clog2(n_chunks) : 1;
  endfunction

endpackage

// File: rtl/full_tree_carry_generator.sv
// Parallel-prefix carry generator: every carry of an N_BIT add in log2(N_BIT) levels.
module full_tree_carry_generator #(
  parameter int unsigned N_BIT = 32
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             carry_in,
  output logic [N_BIT-1:0] p,
  output logic [N_BIT:0]   carry_vector
);

  assign p = a ^ b;

  // carry_in is folded into bit 0's generate so the prefix tree yields true carries.
  always_comb begin
    logic [N_BIT-1:0] g_t;
    logic [N_BIT-1:0] p_t;
    g_t = (a & b) | {{(N_BIT-1){1'b0}}, p[0] & carry_in};
    p_t = p;
    for (int d = 1; d < int'(N_BIT); d = d * 2) begin
      for (int i = int'(N_BIT) - 1; i >= d; i--) begin
        g_t[i] = g_t[i] | (p_t[i] & g_t[i-d]);
        p_t[i] = p_t[i] & p_t[i-d];
      end
    end
    carry_vector = {g_t, carry_in};
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder/subtractor that walks N_CHUNKS chunks, LSB first, through one
// narrow carry generator, with valid/ready handshakes on both sides.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int unsigned N_BIT    = 32,
  parameter int unsigned N_CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_BIT*N_CHUNKS-1:0] operand_1,
  input  logic [N_BIT*N_CHUNKS-1:0] operand_2,
  input  logic                      carry_in,
  input  logic                      subtract,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_BIT*N_CHUNKS-1:0] sum,
  output logic                      carry_out,
  output logic                      overflow
);

  localparam int unsigned W     = N_BIT * N_CHUNKS;
  localparam int unsigned CNT_W = cnt_width(N_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

  wide_add_state_t  state_q, state_d;
  logic [W-1:0]     op1_q, op1_d;
  logic [W-1:0]     op2_q, op2_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_BIT-1:0] chunk_p;
  logic [N_BIT:0]   chunk_cv;
  logic [N_BIT-1:0] chunk_sum;

  full_tree_carry_generator #(.N_BIT(N_BIT)) u_carry_gen (
    .a            (op1_q[N_BIT-1:0]),
    .b            (op2_q[N_BIT-1:0]),
    .carry_in     (carry_q),
    .p            (chunk_p),
    .carry_vector (chunk_cv)
  );

  assign chunk_sum = chunk_p ^ chunk_cv[N_BIT-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Subtraction is a + ~b + 1: operand_2 is inverted at capture and the carry seeded with 1.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op1_d   = operand_1;
          op2_d   = subtract ? ~operand_2 : operand_2;
          carry_d = subtract ? 1'b1 : carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op1_d   = op1_q >> N_BIT;
        op2_d   = op2_q >> N_BIT;
        res_d   = W'({chunk_sum, res_q} >> N_BIT);
        carry_d = chunk_cv[N_BIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CHUNK) begin
          ovf_d   = chunk_cv[N_BIT-1] ^ chunk_cv[N_BIT];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = res_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized, self-checking bench for wide_add_sequencer (8-bit chunks x 4).
module tb_wide_add_sequencer;

  localparam int unsigned N_BIT    = 8;
  localparam int unsigned N_CHUNKS = 4;
  localparam int unsigned W        = N_BIT * N_CHUNKS;
  localparam longint      MAX_S    = 64'sd2147483647;

  logic         clk, rst;
  logic         in_valid, in_ready, carry_in, subtract;
  logic         out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] operand_1, operand_2, sum;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t exp_q[$];
  logic m_busy  = 1'b0;
  int   acc_cyc = 0;

  wide_add_sequencer #(.N_BIT(N_BIT), .N_CHUNKS(N_CHUNKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .carry_in  (carry_in),
    .subtract  (subtract),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain W-bit and signed 64-bit arithmetic.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t   m;
    logic [W:0] u;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      m.s = a - b;
      m.c = (a >= b);
      r   = sa - sb;
    end else begin
      u   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      m.s = u[W-1:0];
      m.c = u[W];
      r   = sa + sb + longint'(cin);
    end
    m.v = (r > MAX_S) || (r < -MAX_S - 1);
    return m;
  endfunction

  // Cycle-level monitor: handshake timing and results against the model.
  initial begin
    logic exp_valid;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_busy = 1'b0;
      end else begin
        exp_valid = m_busy && (cyc - acc_cyc >= int'(N_CHUNKS) + 1);
        chk("mon in_ready", 64'(in_ready), 64'(!m_busy));
        chk("mon out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid && out_valid && exp_q.size() > 0) begin
          chk("mon sum", 64'(sum), 64'(exp_q[0].s));
          chk("mon carry_out", 64'(carry_out), 64'(exp_q[0].c));
          chk("mon overflow", 64'(overflow), 64'(exp_q[0].v));
        end
        if (!m_busy && in_valid) begin
          exp_q.push_back(model(operand_1, operand_2, carry_in, subtract));
          m_busy  = 1'b1;
          acc_cyc = cyc;
        end else if (exp_valid && out_ready) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end
    end
  end

  // Presents a request and returns just after the accepting edge; k = cycle count at accept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, output int k);
    int t;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    operand_1 = a;
    operand_2 = b;
    carry_in  = cin;
    subtract  = sub;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    chk("accept", 64'(in_ready), 64'd1);
    k = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string nm, input int k, input logic [W-1:0] es,
                            input logic ec, input logic ev);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk({nm, " valid"}, 64'(out_valid), 64'd1);
    chk({nm, " latency"}, 64'(cyc - k), 64'(N_CHUNKS + 1));
    chk({nm, " sum"}, 64'(sum), 64'(es));
    chk({nm, " carry"}, 64'(carry_out), 64'(ec));
    chk({nm, " ovf"}, 64'(overflow), 64'(ev));
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic [W-1:0] es, input logic ec, input logic ev);
    int k;
    out_ready = 1'b1;
    send(a, b, cin, sub, k);
    expect_res(nm, k, es, ec, ev);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] special [5];
    special = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    int k;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    carry_in = 1'b0; subtract = 1'b0; operand_1 = '0; operand_2 = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset sum", 64'(sum), 64'd0);
    chk("reset carry_out", 64'(carry_out), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    #19 rst = 1'b0;

    do_op("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("sub borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("sub cin1", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("add cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    do_op("carry chain", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

    // Backpressure: result held in DONE while a new request is waiting.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, k);
    in_valid  = 1'b1;
    operand_1 = 32'h0000_FFFF;
    operand_2 = 32'h0000_FFFF;
    carry_in  = 1'b0;
    subtract  = 1'b0;
    expect_res("bp first", k, 32'h2345_678A, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp hold sum", 64'(sum), 64'h2345_678A);
      chk("bp hold valid", 64'(out_valid), 64'd1);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake no accept", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp idle accept", 64'(in_ready), 64'd1);
    k = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_res("bp second", k, 32'h0001_FFFE, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset while the counter is at 2.
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, k);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    chk("async rst sum", 64'(sum), 64'd0);
    #4 rst = 1'b0;
    do_op("after rst", 32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 32'h0000_01FF, 1'b0, 1'b0);

    // Random traffic with random backpressure; the monitor does the checking.
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      operand_1 = rand_op();
      operand_2 = rand_op();
      carry_in  = 1'($urandom_range(0, 1));
      subtract  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (N_CHUNKS + 4) @(posedge clk);
    @(negedge clk);
    chk("drain out_valid", 64'(out_valid), 64'd0);
    chk("drain in_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
